// File: rtl/fmap_mem_if.sv
// Feature-map buffer port bundle: write port, random-read port, raster-scan handshake and status.
// The master side drives requests into the buffer; the slave side is the buffer itself.
interface fmap_mem_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 8
) ();
    logic              wr_en;
    logic [AW-1:0]     wr_row;
    logic [AW-1:0]     wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [AW-1:0]     rd_row;
    logic [AW-1:0]     rd_col;
    logic              scan_start;
    logic              scan_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              scan_busy;
    logic              scan_done;
    logic              err_oob;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, rd_en, rd_row, rd_col, scan_start, scan_ready,
        input  rd_data, rd_valid, scan_busy, scan_done, err_oob
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, rd_en, rd_row, rd_col, scan_start, scan_ready,
        output rd_data, rd_valid, scan_busy, scan_done, err_oob
    );
endinterface

// File: rtl/fmap_mem.sv
// 2-D signed feature-map buffer with random read and raster-scan streaming; FMAP_ZPAD_EN enables zero-padded reads.
// Latency: reads and first scan element appear 1 cycle after the request; err_oob 1 cycle after the bad access.
// Backpressure: scan output register holds (rd_valid, rd_data stable) while scan_ready is low.
module fmap_mem #(
    parameter int DATA_W = 16,
    parameter int ROW    = 3,
    parameter int COL    = 3,
    parameter int AW     = 8
) (
    input  logic      clk,
    input  logic      rst,
    fmap_mem_if.slave bus
);
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [AW-1:0] ROW_L  = AW'(ROW);
    localparam logic [AW-1:0] COL_L  = AW'(COL);
    localparam logic [RW-1:0] LAST_R = RW'(ROW - 1);
    localparam logic [CW-1:0] LAST_C = CW'(COL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ram [ROW][COL];
    logic [RW-1:0]     r_ptr, nxt_r;
    logic [CW-1:0]     c_ptr, nxt_c;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              err_oob_q;
    logic              wr_ok, wr_oob, rd_in, rd_req, scan_go, accept, last_elem;

    always_comb begin
        wr_ok  = bus.wr_en && (bus.wr_row < ROW_L) && (bus.wr_col < COL_L);
        wr_oob = bus.wr_en && !wr_ok;
`ifdef FMAP_ZPAD_EN
        // Signed addresses: a set MSB is a negative (padding) coordinate.
        rd_in = !bus.rd_row[AW-1] && !bus.rd_col[AW-1] &&
                (bus.rd_row < ROW_L) && (bus.rd_col < COL_L);
`else
        rd_in = (bus.rd_row < ROW_L) && (bus.rd_col < COL_L);
`endif
        scan_go   = (state_q == IDLE) && bus.scan_start;
        rd_req    = (state_q == IDLE) && bus.rd_en && !bus.scan_start;
        accept    = (state_q == SCAN) && rd_valid_q && bus.scan_ready;
        last_elem = (r_ptr == LAST_R) && (c_ptr == LAST_C);
        nxt_r     = r_ptr;
        nxt_c     = c_ptr + CW'(1);
        if (c_ptr == LAST_C) begin
            nxt_c = '0;
            nxt_r = r_ptr + RW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.scan_start) state_d = SCAN;
            SCAN:    if (accept && last_elem) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // RAM is deliberately not reset; writes are legal in every FSM state.
    always_ff @(posedge clk) begin
        if (wr_ok) ram[bus.wr_row[RW-1:0]][bus.wr_col[CW-1:0]] <= bus.wr_data;
    end

    // Output register reads RAM on the same edge as any write, so a colliding read returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            c_ptr      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            err_oob_q <= wr_oob;
            case (state_q)
                IDLE: begin
                    rd_valid_q <= 1'b0;
                    if (scan_go) begin
                        r_ptr      <= '0;
                        c_ptr      <= '0;
                        rd_data_q  <= ram[0][0];
                        rd_valid_q <= 1'b1;
                    end else if (rd_req) begin
                        if (rd_in) begin
                            rd_data_q  <= ram[bus.rd_row[RW-1:0]][bus.rd_col[CW-1:0]];
                            rd_valid_q <= 1'b1;
                        end else begin
`ifdef FMAP_ZPAD_EN
                            rd_data_q  <= '0;
                            rd_valid_q <= 1'b1;
`else
                            err_oob_q  <= 1'b1;
`endif
                        end
                    end
                end
                SCAN: begin
                    if (!rd_valid_q) begin
                        rd_data_q  <= ram[r_ptr][c_ptr];
                        rd_valid_q <= 1'b1;
                    end else if (accept) begin
                        if (last_elem) begin
                            rd_valid_q <= 1'b0;
                        end else begin
                            r_ptr     <= nxt_r;
                            c_ptr     <= nxt_c;
                            rd_data_q <= ram[nxt_r][nxt_c];
                        end
                    end
                end
                default: rd_valid_q <= 1'b0;
            endcase
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.scan_busy = (state_q == SCAN);
    assign bus.scan_done = (state_q == DONE);
    assign bus.err_oob   = err_oob_q;
endmodule

// File: tb/tb_fmap_mem.sv
// Directed bench for fmap_mem: 3x3 16-bit instance plus a 4x5 8-bit instance for the scan order.
module tb_fmap_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fmap_mem_if #(.DATA_W(16), .AW(8)) bus ();
    fmap_mem_if #(.DATA_W(8),  .AW(8)) bus2 ();

    fmap_mem #(.DATA_W(16), .ROW(3), .COL(3), .AW(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fmap_mem #(.DATA_W(8),  .ROW(4), .COL(5), .AW(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        string       name;
        logic        wr_en;
        logic [7:0]  wr_row;
        logic [7:0]  wr_col;
        logic [15:0] wr_data;
        logic        rd_en;
        logic [7:0]  rd_row;
        logic [7:0]  rd_col;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_oob;
    } vec_t;

    vec_t        vt[$];
    logic [15:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input int we, input int wr, input int wc, input int wd,
                       input int re, input int rr, input int rc,
                       input int ev, input int ed, input int eo);
        vec_t v;
        v.name    = nm;
        v.wr_en   = (we != 0);
        v.wr_row  = 8'(wr);
        v.wr_col  = 8'(wc);
        v.wr_data = 16'(wd);
        v.rd_en   = (re != 0);
        v.rd_row  = 8'(rr);
        v.rd_col  = 8'(rc);
        v.e_valid = (ev != 0);
        v.e_data  = 16'(ed);
        v.e_oob   = (eo != 0);
        vt.push_back(v);
    endtask

    // Drives one raster scan on the chosen instance and checks it against exp_q.
    task automatic scan_run(input int which, input int n, input int stall_idx, input int stall_len);
        logic        v, b, dn;
        logic [15:0] d, mask;
        int          stall_left, busy_cnt, done_cnt, done_cyc, last_acc;
        logic [15:0] acc_q[$];
        mask       = (which == 0) ? 16'hFFFF : 16'h00FF;
        stall_left = stall_len;
        busy_cnt   = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        last_acc   = -1;
        if (which == 0) begin
            bus.scan_start = 1'b1;
            bus.scan_ready = 1'b1;
            bus.rd_en      = 1'b1;
            bus.rd_row     = 8'd2;
            bus.rd_col     = 8'd2;
        end else begin
            bus2.scan_start = 1'b1;
            bus2.scan_ready = 1'b1;
        end
        tick();
        bus.scan_start  = 1'b0;
        bus.rd_en       = 1'b0;
        bus2.scan_start = 1'b0;
        for (int cyc = 0; cyc < n + stall_len + 5; cyc++) begin
            if (which == 0) begin
                v = bus.rd_valid; d = bus.rd_data; b = bus.scan_busy; dn = bus.scan_done;
            end else begin
                v = bus2.rd_valid; d = {8'h00, bus2.rd_data}; b = bus2.scan_busy; dn = bus2.scan_done;
            end
            if (cyc == 0) chk("scan_first_valid", 32'(v), 32'd1);
            if (b) busy_cnt++;
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (v && acc_q.size() == stall_idx && stall_left > 0) begin
                chk("stall_hold", 32'(d), 32'(exp_q[stall_idx] & mask));
                stall_left--;
                bus.scan_ready  = (which != 0);
                bus2.scan_ready = (which == 0);
            end else begin
                bus.scan_ready  = 1'b1;
                bus2.scan_ready = 1'b1;
                if (v) begin
                    acc_q.push_back(d);
                    last_acc = cyc;
                end
            end
            tick();
        end
        bus.scan_ready  = 1'b0;
        bus2.scan_ready = 1'b0;
        chk("scan_count", acc_q.size(), n);
        for (int i = 0; i < acc_q.size() && i < n; i++)
            chk("scan_elem", 32'(acc_q[i]), 32'(exp_q[i] & mask));
        chk("scan_busy_cycles", busy_cnt, n + stall_len);
        chk("scan_done_pulses", done_cnt, 1);
        chk("scan_done_timing", done_cyc, last_acc + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        {bus.wr_en, bus.rd_en, bus.scan_start, bus.scan_ready} = '0;
        {bus.wr_row, bus.wr_col, bus.wr_data, bus.rd_row, bus.rd_col} = '0;
        {bus2.wr_en, bus2.rd_en, bus2.scan_start, bus2.scan_ready} = '0;
        {bus2.wr_row, bus2.wr_col, bus2.wr_data, bus2.rd_row, bus2.rd_col} = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.rd_valid),  32'd0);
        chk("rst_data",  32'(bus.rd_data),   32'd0);
        chk("rst_busy",  32'(bus.scan_busy), 32'd0);
        chk("rst_done",  32'(bus.scan_done), 32'd0);
        chk("rst_oob",   32'(bus.err_oob),   32'd0);
        rst = 1'b0;

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                bus.wr_en   = 1'b1;
                bus.wr_row  = 8'(r);
                bus.wr_col  = 8'(c);
                bus.wr_data = 16'(r * 3 + c - 4);
                tick();
            end
        bus.wr_en = 1'b0;
        tick();

        //   name      we wr wc wd  re rr  rc  ev ed  eo
        add("rd21",     0, 0, 0, 0,  1, 2,  1,  1, 3,  0);
        add("rd00",     0, 0, 0, 0,  1, 0,  0,  1, -4, 0);
        add("idle",     0, 0, 0, 0,  0, 0,  0,  0, -4, 0);
        add("rd12",     0, 0, 0, 0,  1, 1,  2,  1, 1,  0);
        add("wr30_bad", 1, 3, 0, 99, 0, 0,  0,  0, 1,  1);
        add("wr41_bad", 1, 4, 1, 99, 0, 0,  0,  0, 1,  1);
        add("rd01",     0, 0, 0, 0,  1, 0,  1,  1, -3, 0);
`ifdef FMAP_ZPAD_EN
        add("rd03_pad", 0, 0, 0, 0,  1, 0,  3,  1, 0,  0);
        add("rdm1_pad", 0, 0, 0, 0,  1, -1, 0,  1, 0,  0);
`else
        add("rd03_oob", 0, 0, 0, 0,  1, 0,  3,  0, -3, 1);
        add("rdff_oob", 0, 0, 0, 0,  1, -1, 0,  0, -3, 1);
`endif
        add("bad_wr_good_rd", 1, 0, 5, 99, 1, 2, 2, 1, 4,  1);
        add("rd01_again", 0, 0, 0, 0,  1, 0,  1,  1, -3, 0);
        add("rw11_old",   1, 1, 1, 7,  1, 1,  1,  1, 0,  0);
        add("rd11_new",   0, 0, 0, 0,  1, 1,  1,  1, 7,  0);
        add("rw11_back",  1, 1, 1, 0,  1, 1,  1,  1, 7,  0);
        add("rd11_zero",  0, 0, 0, 0,  1, 1,  1,  1, 0,  0);

        foreach (vt[i]) begin
            bus.wr_en   = vt[i].wr_en;
            bus.wr_row  = vt[i].wr_row;
            bus.wr_col  = vt[i].wr_col;
            bus.wr_data = vt[i].wr_data;
            bus.rd_en   = vt[i].rd_en;
            bus.rd_row  = vt[i].rd_row;
            bus.rd_col  = vt[i].rd_col;
            tick();
            chk({vt[i].name, "_valid"}, 32'(bus.rd_valid), 32'(vt[i].e_valid));
            chk({vt[i].name, "_data"},  32'(bus.rd_data),  32'(vt[i].e_data));
            chk({vt[i].name, "_oob"},   32'(bus.err_oob),  32'(vt[i].e_oob));
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) exp_q.push_back(16'(i - 4));
        scan_run(0, 9, -1, 0);
        scan_run(0, 9, 4, 3);

        // Reset while element (1,2) = 1 is on the output.
        bus.scan_start = 1'b1;
        bus.scan_ready = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.rd_valid && bus.rd_data == 16'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reach_elem5", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_busy",  32'(bus.scan_busy), 32'd0);
        chk("abort_valid", 32'(bus.rd_valid),  32'd0);
        chk("abort_done",  32'(bus.scan_done), 32'd0);
        rst = 1'b0;
        bus.scan_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'(bus.scan_done), 32'd0);
        end
        scan_run(0, 9, -1, 0);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                bus2.wr_en   = 1'b1;
                bus2.wr_row  = 8'(r);
                bus2.wr_col  = 8'(c);
                bus2.wr_data = 8'(r * 5 + c - 10);
                tick();
            end
        bus2.wr_en = 1'b0;
        tick();
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(16'(i - 10));
        scan_run(1, 20, -1, 0);
        scan_run(1, 20, 7, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
